code_rom_ctrl: RTL and testbench



---
 rtl/code_rom_pkg.sv | 25 ++
 rtl/code_rom_ctrl_if.sv | 43 ++++
 rtl/code_rom_ctrl.sv | 147 ++++++++++++++
 tb/tb_code_rom_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/code_rom_pkg.sv
// Shared constants, state encoding and request-check helper for the code ROM controller.
package code_rom_pkg;

    localparam int NUM_INSTRS      = 8;
    localparam int BYTES_PER_INSTR = 4;
    localparam int NUM_BYTES       = NUM_INSTRS * BYTES_PER_INSTR;
    localparam int INSTR_W         = 32;
    localparam int ADDR_W          = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FETCH = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Misaligned, or the last byte of the word would fall outside the ROM.
    // One extra bit keeps the +3 from wrapping near the top of the address space.
    function automatic logic fetch_addr_bad(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] last_byte;
        last_byte = {1'b0, addr} + (ADDR_W+1)'(BYTES_PER_INSTR - 1);
        return (addr[1:0] != 2'b00) || (last_byte >= (ADDR_W+1)'(NUM_BYTES));
    endfunction

endpackage

// File: rtl/code_rom_ctrl_if.sv
// Host-load, CPU-fetch and ROM-port signals of code_rom_ctrl; master = surroundings, slave = controller.
// load_csum exists only when CODE_ROM_CTRL_CSUM_EN is defined.
interface code_rom_ctrl_if;
    import code_rom_pkg::*;

    logic                load_start;
    logic                load_valid;
    logic [7:0]          load_data;
    logic                load_ready;
    logic                load_done;
    logic                fetch_req;
    logic [ADDR_W-1:0]   fetch_addr;
    logic                fetch_ack;
    logic [INSTR_W-1:0]  fetch_data;
    logic                fetch_err;
    logic                busy;
    logic                rom_we;
    logic [ADDR_W-1:0]   rom_addr;
    logic [7:0]          rom_wdata;
    logic [7:0]          rom_rdata;
`ifdef CODE_ROM_CTRL_CSUM_EN
    logic [7:0]          load_csum;
`endif

    modport master (
        output load_start, load_valid, load_data, fetch_req, fetch_addr, rom_rdata,
        input  load_ready, load_done, fetch_ack, fetch_data, fetch_err, busy,
               rom_we, rom_addr, rom_wdata
`ifdef CODE_ROM_CTRL_CSUM_EN
        , input load_csum
`endif
    );

    modport slave (
        input  load_start, load_valid, load_data, fetch_req, fetch_addr, rom_rdata,
        output load_ready, load_done, fetch_ack, fetch_data, fetch_err, busy,
               rom_we, rom_addr, rom_wdata
`ifdef CODE_ROM_CTRL_CSUM_EN
        , output load_csum
`endif
    );

endinterface

// File: rtl/code_rom_ctrl.sv
// Arbitrates one byte ROM port between a host loader (1 byte/cycle, stalls on load_valid low) and a word fetch
// (ack 5 cycles after request, 1 on error; fetches wait out a load). CODE_ROM_CTRL_CSUM_EN adds load_csum.
module code_rom_ctrl
    import code_rom_pkg::*;
(
    input  logic            clk,
    input  logic            reset_code_rom_n,
    code_rom_ctrl_if.slave  bus
);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [1:0]           beat_q, beat_d;
    logic [23:0]          lanes_q, lanes_d;
    logic [INSTR_W-1:0]   fetch_data_q, fetch_data_d;
    logic                 fetch_err_q, fetch_err_d;
    logic                 fetch_ack_q, fetch_ack_d;
    logic                 load_done_q, load_done_d;

    logic                 rom_we;
    logic [ADDR_W-1:0]    rom_addr;
    logic [7:0]           rom_wdata;
    logic                 load_ready;

    always_ff @(posedge clk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            base_q       <= '0;
            beat_q       <= '0;
            lanes_q      <= '0;
            fetch_data_q <= '0;
            fetch_err_q  <= 1'b0;
            fetch_ack_q  <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            base_q       <= base_d;
            beat_q       <= beat_d;
            lanes_q      <= lanes_d;
            fetch_data_q <= fetch_data_d;
            fetch_err_q  <= fetch_err_d;
            fetch_ack_q  <= fetch_ack_d;
            load_done_q  <= load_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        base_d       = base_q;
        beat_d       = beat_q;
        lanes_d      = lanes_q;
        fetch_data_d = fetch_data_q;
        fetch_err_d  = fetch_err_q;
        fetch_ack_d  = 1'b0;
        load_done_d  = 1'b0;
        rom_we       = 1'b0;
        rom_addr     = '0;
        rom_wdata    = '0;
        load_ready   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d  = LOAD;
                    wr_ptr_d = '0;
                end else if (bus.fetch_req) begin
                    if (fetch_addr_bad(bus.fetch_addr)) begin
                        // Ack is registered, so it is raised on the way into RESP.
                        state_d      = RESP;
                        fetch_ack_d  = 1'b1;
                        fetch_err_d  = 1'b1;
                        fetch_data_d = '0;
                    end else begin
                        state_d = FETCH;
                        base_d  = bus.fetch_addr;
                        beat_d  = '0;
                    end
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                if (bus.load_valid) begin
                    rom_we    = 1'b1;
                    rom_addr  = wr_ptr_q;
                    rom_wdata = bus.load_data;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == ADDR_W'(NUM_BYTES - 1)) begin
                        state_d     = IDLE;
                        load_done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                rom_addr = base_q + ADDR_W'(beat_q);
                beat_d   = beat_q + 1'b1;
                unique case (beat_q)
                    2'd0: lanes_d[7:0]   = bus.rom_rdata;
                    2'd1: lanes_d[15:8]  = bus.rom_rdata;
                    2'd2: lanes_d[23:16] = bus.rom_rdata;
                    2'd3: begin
                        // Top lane goes straight to the output register with the three buffered lanes.
                        fetch_data_d = {bus.rom_rdata, lanes_q};
                        fetch_err_d  = 1'b0;
                        fetch_ack_d  = 1'b1;
                        state_d      = RESP;
                    end
                    default: ;
                endcase
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CODE_ROM_CTRL_CSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            csum_q <= '0;
        end else if (state_q == IDLE && bus.load_start) begin
            csum_q <= '0;
        end else if (rom_we) begin
            csum_q <= csum_q + rom_wdata;
        end
    end

    assign bus.load_csum = csum_q;
`endif

    assign bus.load_ready = load_ready;
    assign bus.load_done  = load_done_q;
    assign bus.fetch_ack  = fetch_ack_q;
    assign bus.fetch_data = fetch_data_q;
    assign bus.fetch_err  = fetch_err_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.rom_we     = rom_we;
    assign bus.rom_addr   = rom_addr;
    assign bus.rom_wdata  = rom_wdata;

endmodule

// File: tb/tb_code_rom_ctrl.sv
// Scoreboard bench for code_rom_ctrl: drivers push expected writes/acks/done pulses, a negedge monitor pops and compares.
module tb_code_rom_ctrl;
    import code_rom_pkg::*;

    localparam int AW = $clog2(NUM_BYTES);

    logic clk = 1'b0;
    logic reset_code_rom_n;
    always #5 clk = ~clk;

    code_rom_ctrl_if bus();

    code_rom_ctrl dut (
        .clk              (clk),
        .reset_code_rom_n (reset_code_rom_n),
        .bus              (bus)
    );

    // Storage stand-in, combinational read.
    logic [7:0] rom_mem [NUM_BYTES];
    always @(posedge clk)
        if (bus.rom_we && bus.rom_addr < ADDR_W'(NUM_BYTES))
            rom_mem[bus.rom_addr[AW-1:0]] <= bus.rom_wdata;
    assign bus.rom_rdata = (bus.rom_addr < ADDR_W'(NUM_BYTES)) ? rom_mem[bus.rom_addr[AW-1:0]] : 8'h00;

    typedef struct { int at; int addr; logic [7:0] data; } wr_t;
    typedef struct { int at; logic [31:0] data; logic err; } ack_t;
    typedef struct { int at; logic [7:0] csum; } done_t;

    wr_t   wr_q[$];
    ack_t  ack_q[$];
    done_t done_q[$];

    logic [7:0] ref_mem [NUM_BYTES];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic exp_busy = 1'b0;
    logic exp_lr = 1'b0;
    logic [31:0] hold_data = '0;
    logic hold_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    wr_t   mw;
    ack_t  ma;
    done_t md;

    always @(negedge clk) begin
        if (!reset_code_rom_n) begin
            chk("rst load_ready", bus.load_ready, 0);
            chk("rst load_done", bus.load_done, 0);
            chk("rst fetch_ack", bus.fetch_ack, 0);
            chk("rst fetch_data", bus.fetch_data, 0);
            chk("rst fetch_err", bus.fetch_err, 0);
            chk("rst busy", bus.busy, 0);
            chk("rst rom_we", bus.rom_we, 0);
            chk("rst rom_addr", bus.rom_addr, 0);
            chk("rst rom_wdata", bus.rom_wdata, 0);
`ifdef CODE_ROM_CTRL_CSUM_EN
            chk("rst load_csum", bus.load_csum, 0);
`endif
            hold_data = '0;
            hold_err  = 1'b0;
        end else begin
            chk("load_ready", bus.load_ready, exp_lr);
            chk("busy", bus.busy, exp_busy);
            if (!exp_busy) begin
                chk("idle rom_addr", bus.rom_addr, 0);
                chk("idle rom_wdata", bus.rom_wdata, 0);
            end
            if (bus.rom_we) begin
                if (wr_q.size() == 0) miss("unexpected rom_we");
                else begin
                    mw = wr_q.pop_front();
                    chk("write cycle", cyc, mw.at);
                    chk("write addr", bus.rom_addr, mw.addr);
                    chk("write data", bus.rom_wdata, mw.data);
                end
            end else if (wr_q.size() > 0 && wr_q[0].at <= cyc) begin
                miss("missing rom write");
                void'(wr_q.pop_front());
            end
            if (bus.fetch_ack) begin
                if (ack_q.size() == 0) miss("unexpected fetch_ack");
                else begin
                    ma = ack_q.pop_front();
                    chk("ack cycle", cyc, ma.at);
                    hold_data = ma.data;
                    hold_err  = ma.err;
                end
            end else if (ack_q.size() > 0 && ack_q[0].at <= cyc) begin
                miss("missing fetch_ack");
                void'(ack_q.pop_front());
            end
            chk("fetch_data", bus.fetch_data, hold_data);
            chk("fetch_err", bus.fetch_err, hold_err);
            if (bus.load_done) begin
                if (done_q.size() == 0) miss("unexpected load_done");
                else begin
                    md = done_q.pop_front();
                    chk("load_done cycle", cyc, md.at);
`ifdef CODE_ROM_CTRL_CSUM_EN
                    chk("load_csum", bus.load_csum, md.csum);
`endif
                end
            end else if (done_q.size() > 0 && done_q[0].at <= cyc) begin
                miss("missing load_done");
                void'(done_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            bus.fetch_req = 1'b0;
            exp_busy = 1'b0;
            exp_lr   = 1'b0;
        end
    endtask

    // pre: fetch_req/fetch_addr were already raised and this is the IDLE cycle that samples them.
    task automatic do_fetch(input int a, input bit pre);
        bit bad;
        logic [31:0] word;
        int lat;
        if (!pre) begin
            step();
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = ADDR_W'(a);
        end
        exp_busy = 1'b0;
        exp_lr   = 1'b0;
        bad  = (a % BYTES_PER_INSTR != 0) || (a + 3 >= NUM_BYTES);
        word = '0;
        if (!bad)
            for (int k = 0; k < 4; k++) word[8*k +: 8] = ref_mem[a + k];
        lat = bad ? 1 : 5;
        ack_q.push_back('{at: cyc + lat, data: word, err: bad});
        repeat (lat) begin
            step();
            exp_busy = 1'b1;
        end
        bus.fetch_req = 1'b0;
    endtask

    task automatic do_load(input bit with_fetch, input int fa, input int stall_at,
                           input bit rnd_stall, input bit seq);
        int n;
        int gap;
        logic [7:0] d;
        logic [7:0] sum;
        step();
        bus.load_start = 1'b1;
        if (with_fetch) begin
            bus.fetch_req  = 1'b1;
            bus.fetch_addr = ADDR_W'(fa);
        end
        exp_busy = 1'b0;
        exp_lr   = 1'b0;
        step();
        bus.load_start = 1'b0;
        n   = 0;
        gap = 0;
        sum = '0;
        while (n < NUM_BYTES) begin
            exp_busy = 1'b1;
            exp_lr   = 1'b1;
            if ((n == stall_at && gap < 3) || (rnd_stall && $urandom_range(0, 3) == 0)) begin
                bus.load_valid = 1'b0;
                bus.load_data  = 8'($urandom);
                if (n == stall_at) gap++;
            end else begin
                d = seq ? 8'(n) : 8'($urandom);
                bus.load_valid = 1'b1;
                bus.load_data  = d;
                wr_q.push_back('{at: cyc, addr: n, data: d});
                ref_mem[n] = d;
                sum = sum + d;
                n++;
            end
            step();
        end
        bus.load_valid = 1'b0;
        exp_busy = 1'b0;
        exp_lr   = 1'b0;
        done_q.push_back('{at: cyc, csum: sum});
    endtask

    initial begin
        int a;
        for (int i = 0; i < NUM_BYTES; i++) rom_mem[i] = 8'($urandom);
        reset_code_rom_n = 1'b0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_code_rom_n = 1'b1;
        idle(2);

        // Sequential image; sum of 0..31 is 0xF0.
        do_load(1'b0, 0, -1, 1'b0, 1'b1);
        do_fetch(8, 1'b0);
        do_fetch(6, 1'b0);
        do_fetch(32, 1'b0);
        do_fetch(28, 1'b0);
        do_fetch(29, 1'b0);
        do_fetch(12'hFFC, 1'b0);
        idle(2);

        // Three-cycle gap in the middle of the stream.
        do_load(1'b0, 0, 10, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095))
                                            : int'($urandom_range(0, 7)) * 4;
            do_fetch(a, 1'b0);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end

        // Load and fetch together: load wins, fetch sees the new image.
        do_load(1'b1, 16, -1, 1'b1, 1'b0);
        do_fetch(16, 1'b1);
        idle(1);

        // Reset during beat 2 of a fetch; nothing may be acknowledged.
        step();
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = ADDR_W'(4);
        exp_busy = 1'b0;
        repeat (3) begin
            step();
            exp_busy = 1'b1;
        end
        reset_code_rom_n = 1'b0;
        bus.fetch_req = 1'b0;
        exp_busy = 1'b0;
        repeat (2) step();
        reset_code_rom_n = 1'b1;
        idle(1);
        do_fetch(4, 1'b0);
        do_fetch(20, 1'b0);

        do_load(1'b0, 0, -1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) do_fetch(int'($urandom_range(0, 7)) * 4, 1'b0);

        for (int i = 0; i < 20 && (wr_q.size() + ack_q.size() + done_q.size()) > 0; i++) idle(1);
        if (wr_q.size() != 0)   miss("writes never seen");
        if (ack_q.size() != 0)  miss("acks never seen");
        if (done_q.size() != 0) miss("load_done never seen");
        idle(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
